key_event_scheduler: RTL
========================

# key_event_scheduler

Shares the PS/2 keyboard event stream between two game-side requesters (e.g. player/dealer FSMs). It accepts the decoder's one-cycle key-event pulse, optionally filters typematic repeats, and buffers events in an 8-entry FIFO. It grants exclusive ownership of the stream to one requester at a time, round-robin, and flushes the queue on every ownership handover.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: one-cycle pulse per decoded make or break event.
- `key_code` in 9: {extend, scan code}; valid while `key_valid`=1.
- `key_make` in 1: 1 = press, 0 = release; valid while `key_valid`=1.
- `req` in 2: ownership requests, level-sensitive; one bit per requester.
- `gnt` out 2: one-hot or zero; the current owner.
- `ev_valid` out 1: FIFO non-empty and owner granted.
- `ev_ready` in 1: owner pops the head entry when `ev_valid` && `ev_ready`.
- `ev_code` out 9: head entry's code.
- `ev_make` out 1: head entry's make flag.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky flag; an event was dropped because the FIFO was full.

## Operation
- FSM states:
  - IDLE: `gnt`=0.
  - OWN: `gnt`=onehot(owner).
  - FLUSH: `gnt`=0, one cycle.
- IDLE → OWN when `req`≠0.
  - If only one bit is set, that requester wins.
  - If both are set, the requester that did not own last wins. `last_owner` resets to 1, so requester 0 wins first.
  - Owner and `last_owner` are updated on the transition.
- OWN → FLUSH when `req[owner]`=0. A request from the other requester does not pre-empt the owner.
- FLUSH → IDLE always. In FLUSH: pointers and `level` are set to 0, and `overflow` is cleared.
- Event capture: on `key_valid`, push {`key_make`, `key_code`} only in OWN. In IDLE and FLUSH, events are discarded and `overflow` is not set.
- Full FIFO: the pushed event is dropped, `overflow` goes to 1, and FIFO contents are unchanged.
- Simultaneous push and pop:
  - When full: both are performed and `level` is unchanged.
  - When empty: a push with `ev_ready`=1 does not pop in that cycle, because `ev_valid` was 0.
- `ev_code`/`ev_make` are the head entry, driven combinationally from the storage array. They hold their last value when empty. Consumers must ignore them unless `ev_valid`=1.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` is never greater than DEPTH.
- Reset values:
  - state IDLE
  - `gnt`=0
  - `ev_valid`=0
  - `level`=0
  - `overflow`=0
  - `ev_code`=0, `ev_make`=0 (storage is cleared)
- Reset in mid-operation discards all queued events immediately.

## Timing
- `req` rising in IDLE at cycle N → `gnt` set at N+1. Events pushed from N+1 onward are queued.
- `key_valid` at cycle N, FIFO empty, OWN → `ev_valid`=1 at N+1.
- Pop at cycle N → the next entry is presented at N+1, and `level` decrements at N+1.
- `req[owner]` falls at N:
  - N+1: FLUSH, `gnt`=0.
  - N+2: IDLE.
  - A re-grant is possible at N+3.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- `KEY_SCHED_REPEAT_FILTER_EN` defined:
  - Tracks `held_code` (9 b) and `held` (1 b).
  - A make with `key_code`==`held_code` while `held`=1 is discarded as a typematic repeat.
  - Any other make is queued and sets `held_code`=`key_code`, `held`=1.
  - A break of `held_code` clears `held`.
  - Breaks are always queued.
  - `held`, `held_code` reset to 0. They are also cleared in FLUSH.
- Macro undefined: every `key_valid` pulse is a push candidate and no filter registers exist.

## Structure
- `key_sched_pkg` holds:
  - the state enum (IDLE, OWN, FLUSH);
  - the event type {make, code[8:0]};
  - `KEY_CODE_W`=9.
- Sub-module `key_event_fifo` provides synchronous write, combinational head read, `level`, full/empty, and a synchronous flush input.
- The scheduler top holds the arbiter FSM, the repeat filter and the overflow flag.

## Test plan
- `req`=01 at cycle 5 → `gnt`=01 at cycle 6. Make 0x01C (A) at cycle 8 → `ev_valid`=1, `ev_code`=0x01C, `ev_make`=1 at cycle 9. Pop at cycle 9 → `level`=0 at cycle 10.
- Both `req` high from reset → `gnt`=01. Drop `req[0]` → FLUSH, then `gnt`=10 within 3 cycles. Raise `req[0]` again and drop `req[1]` → `gnt`=01 (round-robin alternates).
- Owner granted with no pops; 10 makes (codes 0x10–0x19) → `level`=8, `overflow`=1. Entries are popped in order 0x10–0x17. Owner release → `overflow`=0, `level`=0.
- `level`=8 full; push 0x22 with `ev_ready`=1 in the same cycle → head advances, `level`=8, the tail holds 0x22, `overflow` stays 0.
- Filter on: make 0x1C ×3, break 0x1C, make 0x1C → queue holds make, break, make (3 entries). Filter off → 5 entries.
- Assert `rst` with 4 events queued and `gnt`=10 → next cycle `gnt`=0, `level`=0, `ev_valid`=0. Events arriving in IDLE are not queued.

Source files
------------

// File: rtl/key_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_sched_pkg
//  Description : Shared types and constants for the keyboard event
//                scheduler: arbiter state encoding, the queued event
//                record and the key code width.
//  Revision    : 1.0  initial release
// ============================================================================
package key_sched_pkg;

    // Width of {extend, scan code} as delivered by the PS/2 decoder.
    localparam int KEY_CODE_W = 9;

    // Ownership arbiter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // One queued keyboard event: make flag in the MSB, code below it.
    typedef struct packed {
        logic                  make;
        logic [KEY_CODE_W-1:0] code;
    } key_event_t;

endpackage : key_sched_pkg
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Synchronous-write event FIFO with a combinational head
//                read, occupancy count and a synchronous flush.
//                DEPTH must be a power of two and at least 2 so that the
//                pointers wrap naturally.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                flush         - zero pointers and level (contents kept)
//                push, wr_data - write request and data
//                pop           - read request (ignored when empty)
//                rd_data       - head entry (holds last value when empty)
//                level         - occupancy, 0..DEPTH
//                full, empty   - occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_fifo
    import key_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  key_event_t             wr_data,
    input  logic                   pop,
    output key_event_t             rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    key_event_t             mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign empty = (level == '0);
    assign full  = (level == LEVEL_W'(DEPTH));

    // A pop on an empty FIFO is ignored. A push into a full FIFO is only
    // accepted when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign rd_data = mem[rd_ptr];

    // Storage is cleared on reset so the head output reads zero afterwards;
    // a flush only discards entries logically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule : key_event_fifo
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_scheduler
//  Description : Shares the decoded PS/2 key event stream between two
//                requesters. Grants exclusive round-robin ownership, queues
//                events for the owner in a DEPTH-entry FIFO and flushes the
//                queue on every ownership handover.
//                Optional typematic repeat filter: define
//                KEY_SCHED_REPEAT_FILTER_EN to drop repeated makes of the
//                currently held key.
//  Ports       : clk, rst             - clock, asynchronous active-high reset
//                key_valid            - one-cycle decoded event pulse
//                key_code, key_make   - event code and press(1)/release(0)
//                req[1:0]             - level-sensitive ownership requests
//                gnt[1:0]             - current owner, one-hot or zero
//                ev_valid, ev_ready   - head-of-queue handshake to owner
//                ev_code, ev_make     - head entry
//                level                - FIFO occupancy
//                overflow             - sticky event-dropped flag
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_scheduler
    import key_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    input  logic [KEY_CODE_W-1:0]  key_code,
    input  logic                   key_make,
    input  logic [1:0]             req,
    output logic [1:0]             gnt,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [KEY_CODE_W-1:0]  ev_code,
    output logic                   ev_make,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    sched_state_t state;
    logic         owner;
    logic         last_owner;
    logic         winner;
    logic         push_cand;
    logic         pop_req;
    logic         fifo_full;
    logic         fifo_empty;
    logic         flush;
    key_event_t   wr_ev;
    key_event_t   head_ev;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    // With both requests pending the requester that did not own last time
    // wins; a single request always wins outright.
    assign winner = (req == 2'b11) ? ~last_owner : req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= 2'b00;
                    if (req != 2'b00) begin
                        state      <= OWN;
                        owner      <= winner;
                        last_owner <= winner;
                        gnt        <= winner ? 2'b10 : 2'b01;
                    end
                end
                OWN: begin
                    // Only the owner's own release ends ownership; the other
                    // requester never pre-empts.
                    if (!req[owner]) begin
                        state <= FLUSH;
                        gnt   <= 2'b00;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign flush = (state == FLUSH);

    // ------------------------------------------------------------------
    // Event capture and optional repeat filter
    // ------------------------------------------------------------------
`ifdef KEY_SCHED_REPEAT_FILTER_EN
    logic                  held;
    logic [KEY_CODE_W-1:0] held_code;
    logic                  is_repeat;

    assign is_repeat = key_make && held && (key_code == held_code);

    // Tracks the most recently pressed key so auto-repeat makes of it can
    // be dropped; any break of that key re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held      <= 1'b0;
            held_code <= '0;
        end else if (flush) begin
            held      <= 1'b0;
            held_code <= '0;
        end else if (key_valid && (state == OWN)) begin
            if (key_make && !is_repeat) begin
                held      <= 1'b1;
                held_code <= key_code;
            end else if (!key_make && (key_code == held_code)) begin
                held      <= 1'b0;
            end
        end
    end

    assign push_cand = key_valid && (state == OWN) && !is_repeat;
`else
    assign push_cand = key_valid && (state == OWN);
`endif

    assign wr_ev = '{make: key_make, code: key_code};

    // ------------------------------------------------------------------
    // Output handshake
    // ------------------------------------------------------------------
    assign ev_valid = (state == OWN) && !fifo_empty;
    assign pop_req  = ev_valid && ev_ready;
    assign ev_code  = head_ev.code;
    assign ev_make  = head_ev.make;

    // An event is lost only if the FIFO is full and no pop makes room in
    // the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (push_cand && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push_cand),
        .wr_data (wr_ev),
        .pop     (pop_req),
        .rd_data (head_ev),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule : key_event_scheduler
`default_nettype wire
